line_memory_responder: RTL and testbench

//  Responder (memory) end of the cache<->main-memory line protocol: services one 128-bit

---
 rtl/line_memory_responder.sv | 116 +++++++++++
 tb/tb_line_memory_responder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/line_memory_responder.sv
// Line-granular memory responder: one 128-bit read or write at a time, fixed latency.
// Define RESPONDER_STATS_EN to add saturating read_count/write_count outputs.
module line_memory_responder #(
  parameter string PROGRAM    = "../../programs/zero.o",
  parameter int    ADDR_WIDTH = 12,
  parameter int    LINE_WIDTH = 128,
  parameter int    LATENCY    = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  op_init,
  input  logic                  op,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [LINE_WIDTH-1:0] data_in,
  input  logic                  op_done,
  output logic [LINE_WIDTH-1:0] data_out,
  output logic                  data_ready,
  output logic                  memory_in_use
`ifdef RESPONDER_STATS_EN
  ,
  output logic [15:0]           read_count,
  output logic [15:0]           write_count
`endif
);

  localparam int IDX_W = ADDR_WIDTH - 4;
  localparam int LINES = 2 ** IDX_W;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESPOND
  } state_t;

  logic [LINE_WIDTH-1:0] store [LINES];

  state_t                state;
  logic [3:0]            cnt;
  logic                  op_q;
  logic [IDX_W-1:0]      line_q;
  logic [LINE_WIDTH-1:0] wdata_q;
  logic                  commit;
  logic                  unused_addr;

  assign unused_addr = ^address[3:0];
  assign commit      = (state == WAIT) && (cnt == 4'd0);

  // Store has no reset; an aborted WAIT leaves state IDLE so no write lands.
  always_ff @(posedge clk) begin
    if (commit && !op_q)
      store[line_q] <= wdata_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      op_q          <= 1'b0;
      line_q        <= '0;
      wdata_q       <= '0;
      data_out      <= '0;
      data_ready    <= 1'b0;
      memory_in_use <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (enable && op_init) begin
            op_q          <= op;
            line_q        <= address[ADDR_WIDTH-1:4];
            wdata_q       <= data_in;
            cnt           <= 4'(LATENCY);
            memory_in_use <= 1'b1;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            if (op_q)
              data_out <= store[line_q];
            data_ready <= 1'b1;
            state      <= RESPOND;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESPOND: begin
          if (op_done) begin
            data_ready    <= 1'b0;
            memory_in_use <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RESPONDER_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_count  <= '0;
      write_count <= '0;
    end else if (state == RESPOND && op_done) begin
      if (op_q) begin
        if (read_count != 16'hFFFF)
          read_count <= read_count + 16'd1;
      end else begin
        if (write_count != 16'hFFFF)
          write_count <= write_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_line_memory_responder.sv
// Bench for line_memory_responder: two instances (latency 5 and 0) vs. a line-array model.
// Table vectors, hand-built corner sequences, then randomized transactions.
module tb_line_memory_responder;

  typedef struct {
    int           idx;
    bit           rd;
    logic [11:0]  a;
    logic [127:0] d;
    logic [127:0] exp;
  } vec_t;

  localparam logic [127:0] LA = 128'hDEAD_0001_0203_0405_0607_0809_0A0B_BEEF;
  localparam logic [127:0] LB = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
  localparam logic [127:0] LC = 128'hC0C0_C0C0_0000_0000_FFFF_FFFF_3030_3030;
  localparam logic [127:0] LD = 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA;

  logic         clk;
  logic         reset;
  logic         en_a, en_b;
  logic         op_init, op, op_done;
  logic [11:0]  address;
  logic [127:0] data_in;
  logic [127:0] do_a, do_b;
  logic         dr_a, dr_b, bz_a, bz_b;
`ifdef RESPONDER_STATS_EN
  logic [15:0]  rc_a, wc_a, rc_b, wc_b;
`endif

  int checks = 0;
  int errors = 0;

  logic [127:0] mem  [2][256];
  bit           vld  [2][256];
  logic [127:0] last [2];
  int           rcnt [2];
  int           wcnt [2];

  line_memory_responder #(
    .PROGRAM(""), .ADDR_WIDTH(12), .LINE_WIDTH(128), .LATENCY(5)
  ) u_lat5 (
    .clk(clk), .reset(reset), .enable(en_a), .op_init(op_init),
    .op(op), .address(address), .data_in(data_in), .op_done(op_done),
    .data_out(do_a), .data_ready(dr_a), .memory_in_use(bz_a)
`ifdef RESPONDER_STATS_EN
    , .read_count(rc_a), .write_count(wc_a)
`endif
  );

  line_memory_responder #(
    .PROGRAM(""), .ADDR_WIDTH(12), .LINE_WIDTH(128), .LATENCY(0)
  ) u_lat0 (
    .clk(clk), .reset(reset), .enable(en_b), .op_init(op_init),
    .op(op), .address(address), .data_in(data_in), .op_done(op_done),
    .data_out(do_b), .data_ready(dr_b), .memory_in_use(bz_b)
`ifdef RESPONDER_STATS_EN
    , .read_count(rc_b), .write_count(wc_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic rdy(input int i);
    return (i != 0) ? dr_b : dr_a;
  endfunction

  function automatic logic bsy(input int i);
    return (i != 0) ? bz_b : bz_a;
  endfunction

  function automatic logic [127:0] dout(input int i);
    return (i != 0) ? do_b : do_a;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    en_a = 1'b0; en_b = 1'b0; op_init = 1'b0; op_done = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("reset_ready", 128'(rdy(i)), 128'd0);
      chk("reset_busy", 128'(bsy(i)), 128'd0);
      chk("reset_dout", dout(i), 128'd0);
      last[i] = '0;
      rcnt[i] = 0;
      wcnt[i] = 0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // abort_at > 0: reset after that many WAIT edges; < 0: reset while responding
  task automatic xact(input int idx, input bit rd, input logic [11:0] a,
                      input logic [127:0] d, input bit noise,
                      input int abort_at, output logic [127:0] got_d);
    int  k;
    bit  got;
    int  lat;
    logic [7:0] ln;
    ln = a[11:4];
    lat = (idx != 0) ? 1 : 6;
    got_d = 'x;
    @(negedge clk);
    en_a = (idx == 0); en_b = (idx != 0);
    op_init = 1'b1; op = rd; address = a; data_in = d;
    @(posedge clk); #1;
    chk("busy_after_accept", 128'(bsy(idx)), 128'd1);
    chk("ready_after_accept", 128'(rdy(idx)), 128'd0);
    k = 0;
    got = 0;
    while (!got && k < 40) begin
      if (abort_at > 0 && k == abort_at) begin
        do_reset();
        return;
      end
      @(negedge clk);
      if (noise) begin
        op_init = 1'b1;
        op = 1'($urandom);
        address = 12'($urandom);
        data_in = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        op_init = 1'b0; en_a = 1'b0; en_b = 1'b0;
      end
      @(posedge clk); #1;
      k++;
      if (rdy(idx)) got = 1;
      else chk("busy_in_wait", 128'(bsy(idx)), 128'd1);
    end
    chk("latency", 128'(k), 128'(lat));
    got_d = dout(idx);
    if (rd) begin
      chk("read_data", got_d, mem[idx][ln]);
      last[idx] = got_d;
    end else begin
      chk("write_keeps_dout", got_d, last[idx]);
      mem[idx][ln] = d;
      vld[idx][ln] = 1'b1;
    end
    chk("busy_respond", 128'(bsy(idx)), 128'd1);
    if (abort_at < 0) begin
      do_reset();
      return;
    end
    @(negedge clk);
    op_done = 1'b1;
    @(posedge clk); #1;
    op_done = 1'b0;
    chk("ack_ready", 128'(rdy(idx)), 128'd0);
    chk("ack_busy", 128'(bsy(idx)), 128'd0);
    chk("ack_dout_hold", dout(idx), last[idx]);
    if (rd) rcnt[idx]++;
    else wcnt[idx]++;
    @(negedge clk);
    op_init = 1'b0; en_a = 1'b0; en_b = 1'b0;
    if (noise) begin
      @(posedge clk); #1;
      chk("no_accept_on_ack", 128'(bsy(idx)), 128'd0);
    end
  endtask

  vec_t tbl[10];
  logic [127:0] rd_d;

  initial begin
    reset = 1'b0;
    en_a = 1'b0; en_b = 1'b0; op_init = 1'b0; op = 1'b0; op_done = 1'b0;
    address = '0; data_in = '0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 256; j++) begin
        mem[i][j] = 'x;
        vld[i][j] = 1'b0;
      end

    tbl[0] = '{0, 1'b0, 12'h010, LA, 128'd0};
    tbl[1] = '{0, 1'b1, 12'h010, 128'd0, LA};
    tbl[2] = '{0, 1'b0, 12'h020, LB, LA};
    tbl[3] = '{0, 1'b1, 12'h02C, 128'd0, LB};
    tbl[4] = '{0, 1'b0, 12'h030, LC, LB};
    tbl[5] = '{1, 1'b0, 12'h0F0, LD, 128'd0};
    tbl[6] = '{1, 1'b1, 12'h0F0, 128'd0, LD};
    tbl[7] = '{1, 1'b0, 12'hFF0, LB, LD};
    tbl[8] = '{1, 1'b1, 12'hFF5, 128'd0, LB};
    tbl[9] = '{1, 1'b1, 12'h0F8, 128'd0, LD};

    do_reset();

    foreach (tbl[i]) begin
      xact(tbl[i].idx, tbl[i].rd, tbl[i].a, tbl[i].d, 1'b0, 0, rd_d);
      chk($sformatf("tbl%0d_dout", i), rd_d, tbl[i].exp);
    end
`ifdef RESPONDER_STATS_EN
    chk("lat0_read_count", 128'(rc_b), 128'd3);
    chk("lat0_write_count", 128'(wc_b), 128'd2);
`endif

    // new requests pushed during WAIT/RESPOND must be dropped
    xact(0, 1'b1, 12'h024, 128'd0, 1'b1, 0, rd_d);
    chk("noise_read", rd_d, LB);
    xact(1, 1'b1, 12'hFF0, 128'd0, 1'b1, 0, rd_d);
    chk("noise_read0", rd_d, LB);

    // reset mid-WAIT of a write leaves the old line
    xact(0, 1'b0, 12'h030, LD, 1'b0, 2, rd_d);
    xact(0, 1'b1, 12'h030, 128'd0, 1'b0, 0, rd_d);
    chk("abort_keeps_line", rd_d, LC);

    // reset while a read response is pending
    xact(0, 1'b1, 12'h010, 128'd0, 1'b0, -1, rd_d);
    xact(0, 1'b1, 12'h010, 128'd0, 1'b0, 0, rd_d);
    chk("after_respond_reset", rd_d, LA);

    for (int n = 0; n < 40; n++) begin
      int         idx;
      logic [7:0] ln;
      bit         rd;
      idx = int'($urandom_range(0, 1));
      ln = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
      rd = ($urandom_range(0, 1) == 1) && vld[idx][ln];
      xact(idx, rd, {ln, 4'($urandom)},
           {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)),
           0, rd_d);
    end

`ifdef RESPONDER_STATS_EN
    chk("lat5_read_count", 128'(rc_a), 128'(rcnt[0]));
    chk("lat5_write_count", 128'(wc_a), 128'(wcnt[0]));
    chk("lat0_read_count_end", 128'(rc_b), 128'(rcnt[1]));
    chk("lat0_write_count_end", 128'(wc_b), 128'(wcnt[1]));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
